// File: rtl/apb_uart_tx_master_if.sv
// APB bundle between the UART TX master and the UART responder.
// The master drives control/address/data; the responder answers.
interface apb_uart_tx_master_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel,
      output penable,
      output pwrite,
      output paddr,
      output pwdata,
      output pstrb,
      input  prdata,
      input  pready,
      input  pslverr
   );

   modport slave (
      input  psel,
      input  penable,
      input  pwrite,
      input  paddr,
      input  pwdata,
      input  pstrb,
      output prdata,
      output pready,
      output pslverr
   );
endinterface

// File: rtl/apb_uart_tx_master.sv
// APB initiator: programs a 16550 UART, then streams bytes to THR.
// Optional macro UART_TX_FIFO_EN: enables FIFOs, 16 writes per poll.
module apb_uart_tx_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [15:0] DIVISOR   = 16'd1,
   parameter logic [7:0]  LCR_VAL   = 8'h03
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [7:0]           tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic                 init_done_o,
   output logic                 err_o,
   apb_uart_tx_master_if.master apb
);

`ifdef UART_TX_FIFO_EN
   localparam logic [7:0] FCR_VAL    = 8'h07;
   localparam logic [4:0] CREDIT_MAX = 5'd16;
`else
   localparam logic [7:0] FCR_VAL    = 8'h00;
   localparam logic [4:0] CREDIT_MAX = 5'd1;
`endif

   typedef enum logic [2:0] {
      INIT_DLAB,
      INIT_DLL,
      INIT_DLM,
      INIT_LCR,
      INIT_FCR,
      IDLE,
      POLL_LSR,
      WRITE_THR
   } state_e;

   state_e      state_q, state_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic [3:0]  pstrb_q, pstrb_d;
   logic [4:0]  credit_q, credit_d;
   logic [7:0]  hold_q, hold_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        handshake;
   logic        xfer_done;
   logic        thre;
   logic        start;
   state_e      tgt;
   logic [7:0]  tgt_byte;
   logic [7:0]  rd_byte;
   logic [2:0]  reg_r;
   logic        reg_wr;
   logic [7:0]  reg_byte;

   assign handshake = (state_q == IDLE) && tx_valid_i;
   assign xfer_done = psel_q && penable_q && apb.pready;
   // A read that errors never counts as THRE set.
   assign thre      = rd_byte[5] && !apb.pslverr;

   // Pick the read byte from the lane addressed by the current strobe.
   always_comb begin
      rd_byte = apb.prdata[7:0];
      unique case (1'b1)
         pstrb_q[1]: rd_byte = apb.prdata[15:8];
         pstrb_q[2]: rd_byte = apb.prdata[23:16];
         pstrb_q[3]: rd_byte = apb.prdata[31:24];
         default:    rd_byte = apb.prdata[7:0];
      endcase
   end

   // Transfer target: the current state, or the state entered from IDLE.
   always_comb begin
      tgt      = state_q;
      tgt_byte = hold_q;
      if (state_q == IDLE) begin
         tgt      = (credit_q != 5'd0) ? WRITE_THR : POLL_LSR;
         tgt_byte = tx_data_i;
      end
   end

   // Register index, direction and byte for the target transfer.
   always_comb begin
      reg_r    = 3'd0;
      reg_wr   = 1'b0;
      reg_byte = 8'h00;
      case (tgt)
         INIT_DLAB: begin
            reg_r    = 3'd3;
            reg_wr   = 1'b1;
            reg_byte = LCR_VAL | 8'h80;
         end
         INIT_DLL: begin
            reg_r    = 3'd0;
            reg_wr   = 1'b1;
            reg_byte = DIVISOR[7:0];
         end
         INIT_DLM: begin
            reg_r    = 3'd1;
            reg_wr   = 1'b1;
            reg_byte = DIVISOR[15:8];
         end
         INIT_LCR: begin
            reg_r    = 3'd3;
            reg_wr   = 1'b1;
            reg_byte = LCR_VAL;
         end
         INIT_FCR: begin
            reg_r    = 3'd2;
            reg_wr   = 1'b1;
            reg_byte = FCR_VAL;
         end
         POLL_LSR: begin
            reg_r    = 3'd5;
            reg_wr   = 1'b0;
            reg_byte = 8'h00;
         end
         WRITE_THR: begin
            reg_r    = 3'd0;
            reg_wr   = 1'b1;
            reg_byte = tgt_byte;
         end
         default: begin
            reg_r    = 3'd0;
            reg_wr   = 1'b0;
            reg_byte = 8'h00;
         end
      endcase
   end

   // Next state: sequence the APB phases and walk the init/TX flow.
   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      credit_d  = credit_q;
      hold_d    = hold_q;
      done_d    = done_q;
      err_d     = err_q;
      start     = 1'b0;

      if (state_q == IDLE) begin
         if (handshake) begin
            hold_d  = tx_data_i;
            state_d = tgt;
            start   = 1'b1;
         end
      end else if (!psel_q) begin
         start = 1'b1;
      end else if (!penable_q) begin
         penable_d = 1'b1;
      end else if (xfer_done) begin
         psel_d    = 1'b0;
         penable_d = 1'b0;
         if (apb.pslverr) begin
            err_d = 1'b1;
         end
         case (state_q)
            INIT_DLAB: state_d = INIT_DLL;
            INIT_DLL:  state_d = INIT_DLM;
            INIT_DLM:  state_d = INIT_LCR;
            INIT_LCR:  state_d = INIT_FCR;
            INIT_FCR: begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
            POLL_LSR: begin
               if (thre) begin
                  credit_d = CREDIT_MAX;
                  state_d  = WRITE_THR;
               end
            end
            WRITE_THR: begin
               if (credit_q != 5'd0) begin
                  credit_d = credit_q - 5'd1;
               end
               state_d = IDLE;
            end
            default: state_d = state_q;
         endcase
      end

      if (start) begin
         psel_d    = 1'b1;
         penable_d = 1'b0;
         pwrite_d  = reg_wr;
         paddr_d   = BASE_ADDR + {29'd0, reg_r[2], 2'b00};
         pstrb_d   = 4'b0001 << reg_r[1:0];
         pwdata_d  = {24'd0, reg_byte} << {reg_r[1:0], 3'b000};
      end
   end

   // State and registered APB outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= INIT_DLAB;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= 32'd0;
         pwdata_q  <= 32'd0;
         pstrb_q   <= 4'd0;
         credit_q  <= 5'd0;
         hold_q    <= 8'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         credit_q  <= credit_d;
         hold_q    <= hold_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.pwrite  = pwrite_q;
   assign apb.paddr   = paddr_q;
   assign apb.pwdata  = pwdata_q;
   assign apb.pstrb   = pstrb_q;

   assign tx_ready_o  = (state_q == IDLE);
   assign init_done_o = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_apb_uart_tx_master.sv
// Bench for apb_uart_tx_master: scoreboard of expected APB transfers,
// plus latency, error and reset checks.
module tb_apb_uart_tx_master;

`ifdef UART_TX_FIFO_EN
   localparam int          CMAX  = 16;
   localparam logic [31:0] FCR_W = 32'h0007_0000;
`else
   localparam int          CMAX  = 1;
   localparam logic [31:0] FCR_W = 32'h0000_0000;
`endif

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } xfer_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       init_done;
   logic       err;

   apb_uart_tx_master_if apb();

   apb_uart_tx_master #(
      .BASE_ADDR(32'h0000_0000),
      .DIVISOR  (16'h0123),
      .LCR_VAL  (8'h03)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .tx_data_i  (tx_data),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .init_done_o(init_done),
      .err_o      (err),
      .apb        (apb)
   );

   xfer_t exp_q[$];
   int    n_checks = 0;
   int    n_fail = 0;
   int    stall = 0;
   int    thre_zero = 0;
   int    mcredit = 0;
   bit    inject_err = 0;
   bit    lsr_done = 0;
   bit    thr_done = 0;

   initial forever #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic void push(input logic wr, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] d);
      xfer_t x;
      x.wr   = wr;
      x.addr = a;
      x.strb = s;
      x.data = d;
      exp_q.push_back(x);
   endfunction

   // Responder: wait states and error on THR writes, THRE from a counter.
   initial begin : responder
      bit is_thr;
      apb.pready  = 1'b1;
      apb.pslverr = 1'b0;
      apb.prdata  = 32'h0000_2000;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            stall      = 0;
            thre_zero  = 0;
            inject_err = 0;
            lsr_done   = 0;
            thr_done   = 0;
         end
         if (lsr_done) begin
            if (thre_zero > 0) thre_zero--;
            lsr_done = 0;
         end
         if (thr_done) begin
            inject_err = 0;
            thr_done   = 0;
         end
         is_thr = apb.psel && apb.penable && apb.pwrite &&
                  apb.paddr == 32'h0 && apb.pstrb == 4'b0001;
         if (is_thr && stall > 0) begin
            apb.pready = 1'b0;
            stall--;
         end else begin
            apb.pready = 1'b1;
         end
         apb.pslverr = inject_err && is_thr && apb.pready;
         apb.prdata  = (thre_zero > 0) ? 32'h0 : 32'h0000_2000;
      end
   end

   // Monitor: protocol checks and scoreboard compare on each completion.
   initial begin : monitor
      xfer_t       e;
      logic [31:0] la;
      logic [31:0] ld;
      logic [3:0]  ls;
      logic        lw;
      bit          gap;
      gap = 0;
      la  = 0;
      ld  = 0;
      ls  = 0;
      lw  = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            gap = 0;
         end else begin
            if (gap) begin
               check("gap_psel_low", apb.psel, 0);
               gap = 0;
            end
            if (apb.psel && !apb.penable) begin
               check("pstrb_onehot", {31'd0, $onehot(apb.pstrb)}, 1);
               la = apb.paddr;
               ld = apb.pwdata;
               ls = apb.pstrb;
               lw = apb.pwrite;
            end else if (apb.psel && apb.penable) begin
               check("stable_paddr", apb.paddr, la);
               check("stable_pwdata", apb.pwdata, ld);
               check("stable_pstrb", {28'd0, apb.pstrb}, {28'd0, ls});
               check("stable_pwrite", {31'd0, apb.pwrite}, {31'd0, lw});
               if (apb.pready) begin
                  gap = 1;
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_xfer: got addr 0x%0h wr %0d, expected none",
                              apb.paddr, apb.pwrite);
                  end else begin
                     e = exp_q.pop_front();
                     check("xfer_wr", {31'd0, apb.pwrite}, {31'd0, e.wr});
                     check("xfer_addr", apb.paddr, e.addr);
                     check("xfer_strb", {28'd0, apb.pstrb}, {28'd0, e.strb});
                     if (e.wr) check("xfer_data", apb.pwdata, e.data);
                  end
                  if (!apb.pwrite && apb.paddr == 32'h4) lsr_done = 1;
                  if (apb.pwrite && apb.paddr == 32'h0 &&
                      apb.pstrb == 4'b0001) thr_done = 1;
               end
            end
         end
      end
   end

   task automatic do_reset();
      int k;
      rst = 1'b1;
      #1;
      check("rst_psel", {31'd0, apb.psel}, 0);
      check("rst_penable", {31'd0, apb.penable}, 0);
      check("rst_pwrite", {31'd0, apb.pwrite}, 0);
      check("rst_paddr", apb.paddr, 0);
      check("rst_pwdata", apb.pwdata, 0);
      check("rst_pstrb", {28'd0, apb.pstrb}, 0);
      check("rst_tx_ready", {31'd0, tx_ready}, 0);
      check("rst_init_done", {31'd0, init_done}, 0);
      check("rst_err", {31'd0, err}, 0);
      exp_q.delete();
      mcredit  = 0;
      tx_valid = 1'b0;
      repeat (2) @(negedge clk);
      push(1, 32'h0, 4'b1000, 32'h8300_0000);
      push(1, 32'h0, 4'b0001, 32'h0000_0023);
      push(1, 32'h0, 4'b0010, 32'h0000_0100);
      push(1, 32'h0, 4'b1000, 32'h0300_0000);
      push(1, 32'h0, 4'b0100, FCR_W);
      rst = 1'b0;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!init_done && k < 100);
      check("init_latency", k, 15);
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int nz,
                            input int st, input bit er);
      int k;
      int lat;
      bit poll;
      k = 0;
      while (!tx_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("tx_ready_wait", {31'd0, tx_ready}, 1);
      if (!tx_ready) return;
      poll = (mcredit == 0);
      if (poll) begin
         thre_zero = nz;
         repeat (nz + 1) push(0, 32'h4, 4'b0010, 32'h0);
         mcredit = CMAX;
      end
      stall      = st;
      inject_err = er;
      push(1, 32'h0, 4'b0001, {24'd0, b});
      mcredit--;
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      k = 1;
      while (!tx_ready && k < 500) begin
         @(posedge clk);
         #1;
         k++;
      end
      lat = (poll ? 3 * (nz + 1) : 0) + 3 + st;
      check("byte_latency", k, lat);
      @(negedge clk);
   endtask

   task automatic reset_mid_thr();
      int k;
      k = 0;
      while (!tx_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("tx_ready_wait_rst", {31'd0, tx_ready}, 1);
      if (mcredit == 0) begin
         thre_zero = 0;
         push(0, 32'h4, 4'b0010, 32'h0);
      end
      stall    = 50;
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      k = 0;
      while (!(apb.psel && apb.penable && apb.pwrite) && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("thr_access_reached",
            {31'd0, apb.psel && apb.penable && apb.pwrite}, 1);
      @(negedge clk);
      do_reset();
   endtask

   initial begin : stim
      #2;
      do_reset();
      send_byte(8'h41, 0, 0, 0);
      send_byte(8'h5A, 3, 0, 0);
      check("err_before", {31'd0, err}, 0);
      send_byte(8'h7E, 0, 2, 1);
      check("err_set", {31'd0, err}, 1);
      send_byte(8'h33, 0, 0, 0);
      check("err_sticky", {31'd0, err}, 1);
      reset_mid_thr();
`ifdef UART_TX_FIFO_EN
      for (int i = 0; i < 17; i++) begin
         send_byte(8'(8'h60 + i), 0, 0, 0);
      end
`else
      send_byte(8'hA5, 0, 0, 0);
      send_byte(8'h0D, 1, 0, 0);
`endif
      repeat (5) @(negedge clk);
      check("exp_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_uart_tx_master.md
# apb_uart_tx_master

APB initiator that drives a 16550-compatible UART transmitter from a byte stream. After reset it programs the divisor latch, the line format and the FCR. It then forwards each accepted byte to THR, gating writes on LSR.THRE. It sits between on-chip logic (boot/debug printer) and the peripheral APB bus, and is the counterpart of the UART APB responder.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: UART base. Must be 8-byte aligned.
- `DIVISOR`, default 16'd1: baud divisor written to DLL/DLM.
- `LCR_VAL`, default 8'h03: final line control value (8N1). Bit 7 must be 0.
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `tx_data_i`, input, 8: byte to transmit.
- `tx_valid_i`, input, 1: byte valid.
- `tx_ready_o`, output, 1: byte accepted when `tx_valid_i && tx_ready_o`.
- `init_done_o`, output, 1: init sequence complete. Sticky until reset.
- `err_o`, output, 1: sticky; set on any transfer completing with `pslverr_i=1`.
- `psel_o`, `penable_o`, `pwrite_o`, output, 1 each: APB control.
- `paddr_o`, output, 32: APB address.
- `pwdata_o`, output, 32: APB write data.
- `pstrb_o`, output, 4: APB byte strobes. Always one-hot during a transfer.
- `prdata_i`, input, 32: APB read data.
- `pready_i`, input, 1: APB ready.
- `pslverr_i`, input, 1: APB error.

## Operation
- **Register r (0..7) addressing:**
  - `paddr_o = BASE_ADDR + {r[2],2'b00}`
  - `pstrb_o = 1 << r[1:0]`
  - byte in `pwdata_o` lane `r[1:0]`, other lanes 0
  - read byte from `prdata_i` lane `r[1:0]`
- **FSM states:** INIT_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR, IDLE, POLL_LSR, WRITE_THR.
- **Init writes, in order:**
  - LCR (r3) = `LCR_VAL|8'h80`
  - DLL (r0) = `DIVISOR[7:0]`
  - DLM (r1) = `DIVISOR[15:8]`
  - LCR (r3) = `LCR_VAL`
  - FCR (r2) = FCR value (see Configuration)
  - Then `init_done_o`=1 and the FSM enters IDLE.
- **IDLE:**
  - `tx_ready_o`=1 only in IDLE.
  - On handshake, byte is latched into the holding register.
  - If `credit>0`, go to WRITE_THR; otherwise go to POLL_LSR.
- **POLL_LSR:**
  - Read LSR (r5) and sample bit 5 (`prdata_i[13]`).
  - Bit set: `credit = CREDIT_MAX`, go to WRITE_THR.
  - Bit clear: issue another read.
- **WRITE_THR:**
  - Write the held byte to THR (r0).
  - `credit` decrements on completion; FSM returns to IDLE.
- **Credit counter:**
  - 5 bits, reset 0, saturates at 0.
  - Never incremented except by reloading from a THRE=1 poll.
- **Errors:** `pslverr_i` does not abort. The transfer counts as complete, `err_o` sets, and the sequence continues. A POLL result read with `pslverr_i=1` is treated as THRE=0.
- **Mid-operation reset:** all state is lost. After release, the full init sequence is replayed. An in-flight byte is dropped.

## Timing
- **APB transfer:**
  - SETUP: `psel_o`=1, `penable_o`=0, for one cycle.
  - ACCESS: `penable_o`=1, held until `pready_i`=1.
  - `paddr_o`, `pwrite_o`, `pwdata_o`, `pstrb_o` stay stable from SETUP through the completing ACCESS cycle.
- After each completed transfer, `psel_o`=0 for exactly one cycle before the next SETUP. No back-to-back transfers.
- **Reset values:**
  - `psel_o`, `penable_o`, `pwrite_o`, `tx_ready_o`, `init_done_o`, `err_o` = 0
  - `paddr_o`, `pwdata_o`, `pstrb_o` = 0
  - `credit` = 0
- **Init latency:** with `pready_i` tied to 1, 5 transfers × 3 cycles. `init_done_o` rises 15 cycles after reset release.
- **Byte latency:** handshake at cycle T with `credit>0` and `pready_i`=1:
  - SETUP at T+1, ACCESS at T+2.
  - `tx_ready_o` high again at T+3.
- With `credit`=0, one extra LSR read (3 cycles) precedes the write.
- Outputs are registered; no combinational path from APB inputs to APB outputs.

## Configuration
- **`UART_TX_FIFO_EN` defined:**
  - FCR written as 8'h07 (enable and clear FIFOs).
  - `CREDIT_MAX`=16, so one THRE=1 poll permits 16 THR writes without polling.
- **Undefined:**
  - FCR written as 8'h00.
  - `CREDIT_MAX`=1, so every byte is preceded by an LSR poll.

## Test plan
- **Init sequence:** reset, `DIVISOR`=16'h0123, `pready_i`=1, `BASE_ADDR`=0. Required writes:
  - (0x0, 4'b1000, 0x8300_0000)
  - (0x0, 4'b0001, 0x23)
  - (0x0, 4'b0010, 0x0100)
  - (0x0, 4'b1000, 0x0300_0000)
  - FCR at (0x0, 4'b0100, 0x0 or 0x07_0000)
  - `init_done_o` rises at cycle 15.
- **Single byte, FIFO off:** send 0x41 with responder returning `prdata_i[13]`=1.
  - LSR read at (0x4, 4'b0010).
  - Then THR write (0x0, 4'b0001, 0x41).
  - `tx_ready_o` returns 6 cycles after the handshake.
- **THRE stall:** responder returns THRE=0 for 3 polls, then 1. Required: 4 LSR reads, then exactly one THR write; no THR write before THRE=1.
- **FIFO burst (`UART_TX_FIFO_EN`):** stream 17 bytes. Required: 1 poll, 16 THR writes, 1 poll, 1 THR write.
- **Wait states and error:** `pready_i` low for 2 cycles during a THR write, with `pslverr_i`=1 on completion.
  - Signals stay stable throughout.
  - `err_o`=1 after completion, sticky.
  - The next byte proceeds normally.
- **Reset during ACCESS of a THR write:** all outputs return to reset values immediately; the init sequence restarts after release.
